// File: rtl/stage_record_pipe_pkg.sv
// Stage-record layout shared by the record pipe and the operand forwarders.
package stage_rec_pkg;

  localparam int REC_W       = 40;
  localparam int REC_VALID   = 39;
  localparam int REC_IS_LOAD = 38;
  localparam int REC_REG_WR  = 37;
  localparam int REC_RD_HI   = 36;
  localparam int REC_RD_LO   = 32;
  localparam int REC_DATA_HI = 31;
  localparam int REC_DATA_LO = 0;

  typedef struct packed {
    logic        valid;
    logic        is_load;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] data;
  } stage_rec_t;

  localparam stage_rec_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/stage_record_pipe_rec_reg.sv
// Stage-record register: async reset to a bubble, hold has priority over bubble insert.
module stage_rec_reg
  import stage_rec_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       i_hold,
  input  logic       i_bubble,
  input  stage_rec_t i_d,
  output stage_rec_t o_q
);

  stage_rec_t r_q;

  // Record update: hold, else bubble, else capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         r_q <= STAGE_BUBBLE;
    else if (i_hold)   r_q <= r_q;
    else if (i_bubble) r_q <= STAGE_BUBBLE;
    else               r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/stage_record_pipe.sv
// EX/MEM and MEM/WB record pipe with load handshake, hazard bubbles and writeback port.
module stage_record_pipe
  import stage_rec_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  input  logic        ex_is_load_i,
  input  logic        ex_reg_write_i,
  input  logic [4:0]  ex_rd_i,
  input  logic [31:0] ex_result_i,
  input  logic        load_use_hazard_i,
  input  logic        flush_i,
  output logic        dmem_req_o,
  output logic [31:0] dmem_addr_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [39:0] ex_stage_o,
  output logic [39:0] mem_stage_o,
  output logic        stall_o,
  output logic        wb_en_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o
);

  stage_rec_t w_ex, w_mem, w_ex_d, w_mem_d;
  logic       w_stall;

  // Incoming execute record.
  always_comb begin
    w_ex_d           = STAGE_BUBBLE;
    w_ex_d.valid     = ex_valid_i;
    w_ex_d.is_load   = ex_is_load_i;
    w_ex_d.reg_write = ex_reg_write_i;
    w_ex_d.rd        = ex_rd_i;
    w_ex_d.data      = ex_result_i;
  end

  // EX advancing into MEM: a load swaps its address for the returned data.
  always_comb begin
    w_mem_d = w_ex;
    if (w_ex.is_load) w_mem_d.data = dmem_rdata_i;
  end

  assign dmem_req_o  = w_ex.valid & w_ex.is_load;
  assign dmem_addr_o = w_ex.data;
  assign w_stall     = dmem_req_o & ~dmem_ack_i;
  assign stall_o     = w_stall;

  // A stall freezes EX; flush/hazard only act once EX is free to advance.
  stage_rec_reg u_ex (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_hold   (w_stall),
    .i_bubble (flush_i | load_use_hazard_i),
    .i_d      (w_ex_d),
    .o_q      (w_ex)
  );

  // MEM never holds; it takes a bubble for every stalled cycle.
  stage_rec_reg u_mem (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_hold   (1'b0),
    .i_bubble (w_stall),
    .i_d      (w_mem_d),
    .o_q      (w_mem)
  );

  assign ex_stage_o  = w_ex;
  assign mem_stage_o = w_mem;
  assign wb_en_o     = w_mem.valid & w_mem.reg_write & (w_mem.rd != 5'd0);
  assign wb_rd_o     = w_mem.rd;
  assign wb_data_o   = w_mem.data;

endmodule

// File: tb/tb_stage_record_pipe.sv
// Directed table-driven bench for stage_record_pipe plus an async-reset sequence.
module tb_stage_record_pipe;

  logic        clk, rst;
  logic        ex_valid, ex_is_load, ex_reg_write;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        haz, flush;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [39:0] ex_stage, mem_stage;
  logic        stall, wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int errors = 0;
  int checks = 0;

  stage_record_pipe dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .ex_valid_i        (ex_valid),
    .ex_is_load_i      (ex_is_load),
    .ex_reg_write_i    (ex_reg_write),
    .ex_rd_i           (ex_rd),
    .ex_result_i       (ex_result),
    .load_use_hazard_i (haz),
    .flush_i           (flush),
    .dmem_req_o        (dmem_req),
    .dmem_addr_o       (dmem_addr),
    .dmem_ack_i        (dmem_ack),
    .dmem_rdata_i      (dmem_rdata),
    .ex_stage_o        (ex_stage),
    .mem_stage_o       (mem_stage),
    .stall_o           (stall),
    .wb_en_o           (wb_en),
    .wb_rd_o           (wb_rd),
    .wb_data_o         (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v, l, w;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        haz, fl, ack;
    logic [31:0] rdata;
    logic [39:0] e_ex, e_mem;
    logic        e_req, e_stall, e_wb;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, l, w, input logic [4:0] rd, input logic [31:0] res,
                              input logic hz, fl, ack, input logic [31:0] rdata,
                              input logic [39:0] e_ex, e_mem, input logic e_req, e_stall, e_wb);
    vec_t t;
    t.v = v; t.l = l; t.w = w; t.rd = rd; t.res = res;
    t.haz = hz; t.fl = fl; t.ack = ack; t.rdata = rdata;
    t.e_ex = e_ex; t.e_mem = e_mem; t.e_req = e_req; t.e_stall = e_stall; t.e_wb = e_wb;
    return t;
  endfunction

  task automatic drive_idle();
    ex_valid = 0; ex_is_load = 0; ex_reg_write = 0; ex_rd = 0; ex_result = 0;
    haz = 0; flush = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  initial begin
    // Expected columns are the state seen in that cycle (before its edge); inputs are applied in it.
    //            v  l  w  rd  res           hz fl ak rdata          exp ex              exp mem         req st wb
    tbl[0]  = mk(1, 0, 1, 5,  32'h1234,     0, 0, 0, 32'h0,        40'h0,              40'h0,              0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0,  32'h0,        0, 0, 0, 32'h0,        40'hA5_0000_1234,   40'h0,              0, 0, 0);
    tbl[2]  = mk(1, 1, 1, 3,  32'h100,      0, 0, 0, 32'h0,        40'h0,              40'hA5_0000_1234,   0, 0, 1);
    tbl[3]  = mk(0, 0, 0, 0,  32'h0,        0, 0, 0, 32'h0,        40'hE3_0000_0100,   40'h0,              1, 1, 0);
    tbl[4]  = mk(1, 0, 1, 9,  32'h999,      0, 1, 0, 32'h0,        40'hE3_0000_0100,   40'h0,              1, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0,  32'h0,        0, 0, 1, 32'hDEADBEEF, 40'hE3_0000_0100,   40'h0,              1, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0,  32'h0,        0, 0, 1, 32'h12345678, 40'h0,              40'hE3_DEAD_BEEF,   0, 0, 1);
    tbl[7]  = mk(1, 0, 1, 0,  32'h55,       0, 0, 0, 32'h0,        40'h0,              40'h0,              0, 0, 0);
    tbl[8]  = mk(1, 0, 1, 6,  32'h66,       0, 0, 0, 32'h0,        40'hA0_0000_0055,   40'h0,              0, 0, 0);
    tbl[9]  = mk(1, 0, 1, 4,  32'h44,       0, 1, 0, 32'h0,        40'hA6_0000_0066,   40'hA0_0000_0055,   0, 0, 0);
    tbl[10] = mk(1, 1, 1, 7,  32'h200,      0, 0, 0, 32'h0,        40'h0,              40'hA6_0000_0066,   0, 0, 1);
    tbl[11] = mk(1, 0, 1, 8,  32'h88,       1, 0, 1, 32'hCAFE0000, 40'hE7_0000_0200,   40'h0,              1, 0, 0);
    tbl[12] = mk(1, 0, 1, 8,  32'h88,       0, 0, 0, 32'h0,        40'h0,              40'hE7_CAFE_0000,   0, 0, 1);
    tbl[13] = mk(0, 0, 0, 0,  32'h0,        0, 0, 0, 32'h0,        40'hA8_0000_0088,   40'h0,              0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0,  32'h0,        0, 0, 0, 32'h0,        40'h0,              40'hA8_0000_0088,   0, 0, 1);

    drive_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    for (int i = 0; i < 15; i++) begin
      ex_valid = tbl[i].v; ex_is_load = tbl[i].l; ex_reg_write = tbl[i].w;
      ex_rd = tbl[i].rd; ex_result = tbl[i].res;
      haz = tbl[i].haz; flush = tbl[i].fl; dmem_ack = tbl[i].ack; dmem_rdata = tbl[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d ex_stage", i),  ex_stage,  tbl[i].e_ex);
      chk($sformatf("v%0d mem_stage", i), mem_stage, tbl[i].e_mem);
      chk($sformatf("v%0d dmem_req", i),  {39'd0, dmem_req}, {39'd0, tbl[i].e_req});
      chk($sformatf("v%0d stall", i),     {39'd0, stall},    {39'd0, tbl[i].e_stall});
      chk($sformatf("v%0d wb_en", i),     {39'd0, wb_en},    {39'd0, tbl[i].e_wb});
      chk($sformatf("v%0d wb_rd", i),     {35'd0, wb_rd},    {35'd0, tbl[i].e_mem[36:32]});
      chk($sformatf("v%0d wb_data", i),   {8'd0, wb_data},   {8'd0, tbl[i].e_mem[31:0]});
      if (tbl[i].e_req)
        chk($sformatf("v%0d dmem_addr", i), {8'd0, dmem_addr}, {8'd0, tbl[i].e_ex[31:0]});
      @(posedge clk);
      #1;
    end

    // Async reset with an outstanding load request, then a late ack while in and after reset.
    drive_idle();
    ex_valid = 1; ex_is_load = 1; ex_reg_write = 1; ex_rd = 2; ex_result = 32'h300;
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    chk("pre-reset ex_stage", ex_stage, 40'hE2_0000_0300);
    chk("pre-reset dmem_req", {39'd0, dmem_req}, 40'd1);
    #2 rst = 1;
    #1;
    chk("async reset ex_stage",  ex_stage,  40'h0);
    chk("async reset mem_stage", mem_stage, 40'h0);
    chk("async reset dmem_req",  {39'd0, dmem_req}, 40'd0);
    chk("async reset stall",     {39'd0, stall},    40'd0);
    chk("async reset wb",        {wb_en, wb_rd, wb_data}, 38'd0);
    dmem_ack = 1; dmem_rdata = 32'hBADBAD00;
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    chk("late ack ex_stage",  ex_stage,  40'h0);
    chk("late ack mem_stage", mem_stage, 40'h0);
    chk("late ack wb_en",     {39'd0, wb_en}, 40'd0);
    drive_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
